mem_controller: RTL
===================

# mem_controller

Data memory controller that arbitrates per-thread load/store requests from the compute cores onto a smaller number of external memory channels. It sits directly downstream of each core's `data_mem_*` ports, one consumer per thread LSU, and upstream of the data memory model or device. Each memory channel runs its own request/ready state machine. The controller relays one consumer transaction per channel at a time and holds the consumer's ready until that consumer withdraws its request.

## Interface
- `ADDR_BITS`, 8, address width
- `DATA_BITS`, 8, data width
- `NUM_CONSUMERS`, 8, consumer ports (cores × threads per core)
- `NUM_CHANNELS`, 2, memory channels (1..NUM_CONSUMERS)
- `clk` input 1: single clock, all logic on rising edge
- `reset` input 1: synchronous, active-high
- `consumer_read_request` input NUM_CONSUMERS: per-consumer read request, held until ready
- `consumer_read_address` input NUM_CONSUMERS×ADDR_BITS: read address
- `consumer_read_ready` output NUM_CONSUMERS: read data valid; held until request drops
- `consumer_read_data` output NUM_CONSUMERS×DATA_BITS: returned read data
- `consumer_write_request` input NUM_CONSUMERS: per-consumer write request
- `consumer_write_address` input NUM_CONSUMERS×ADDR_BITS: write address
- `consumer_write_data` input NUM_CONSUMERS×DATA_BITS: write data
- `consumer_write_ready` output NUM_CONSUMERS: write done; held until request drops
- `mem_read_request` output NUM_CHANNELS: channel read request
- `mem_read_address` output NUM_CHANNELS×ADDR_BITS: channel read address
- `mem_read_ready` input NUM_CHANNELS: memory read complete, data valid this cycle
- `mem_read_data` input NUM_CHANNELS×DATA_BITS: memory read data
- `mem_write_request` output NUM_CHANNELS: channel write request
- `mem_write_address` output NUM_CHANNELS×ADDR_BITS: channel write address
- `mem_write_data` output NUM_CHANNELS×DATA_BITS: channel write data
- `mem_write_ready` input NUM_CHANNELS: memory write complete

## Operation
- Per-channel FSM with states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE: the channel selects one unclaimed consumer whose read or write request is high. If that consumer has both requests high, the read is served first. The channel sets the consumer's claim bit, latches address (and write data), and asserts `mem_read_request` or `mem_write_request` on the next edge. It then moves to the matching WAITING state.
- Within one cycle, channels are evaluated in ascending index order. A consumer claimed by a lower channel in that cycle is invisible to higher channels, so no consumer is ever served by two channels.
- READ_WAITING: when `mem_read_ready`=1, on that edge the channel drops `mem_read_request`, registers `mem_read_data` into `consumer_read_data[c]`, sets `consumer_read_ready[c]`=1 and moves to READ_RELAYING.
- WRITE_WAITING: when `mem_write_ready`=1, the channel drops `mem_write_request`, sets `consumer_write_ready[c]`=1 and moves to WRITE_RELAYING.
- RELAYING: ready and data are held until the consumer's request is sampled low. On that edge ready clears, the claim clears and the FSM returns to IDLE.
- `consumer_read_data` keeps its last value after ready drops.
- Unselected mem address/data outputs hold their last value.

## Timing
- Reset value of every output is 0. All FSMs go to IDLE and all claims clear. This holds for a reset mid-transaction too: in-flight memory requests are abandoned, and memory must tolerate a request dropping without a ready.
- Minimum read latency: request sampled at edge 0 → `mem_read_request` high after edge 0. Memory ready in the following cycle → `consumer_read_ready` high after edge 1.
- Consumer drops request → ready low one edge later. The channel can accept a new consumer in the cycle after returning to IDLE (one idle cycle per transaction).
- Mem request is never asserted in the same cycle its ready was sampled.
- A `mem_*_ready` pulse while not in WAITING is ignored.
- More requesters than channels: excess consumers wait with request held and nothing is lost.

## Configuration
- `MEM_CONTROLLER_RR_ARB_EN` defined: each channel keeps a round-robin pointer. Search starts at (last served consumer + 1) mod NUM_CONSUMERS, and the pointer updates when a consumer is claimed.
- Not defined: fixed priority, where the lowest-index eligible consumer wins.

## Test plan
- Single read, NUM_CHANNELS=1: consumer 3 reads addr 0x10, memory returns 0x5A with ready 2 cycles later → `consumer_read_ready[3]`=1 with data 0x5A. Ready clears one edge after the request drops.
- Single write: consumer 0 writes 0x33 to 0x20 → `mem_write_address`=0x20 and `mem_write_data`=0x33. `consumer_write_ready[0]` goes high after `mem_write_ready`.
- Contention: all 8 consumers read at once with 2 channels → every consumer served exactly once, at most 2 concurrent, no consumer on both channels.
- Arbitration order: consumers 1, 2 and 5 hold requests on 1 channel → with the macro the service order is 1, 2, 5 and the pointer wraps. Without it, consumer 1 is re-served first if it re-requests.
- Read and write both high on consumer 4 → read completes first, then the write.
- Reset asserted during READ_WAITING → next edge all outputs 0. A later request starts cleanly.

Source files
------------

// File: rtl/mem_controller_if.sv
// Bus bundle for mem_controller: the per-consumer load/store ports on one side
// and the external memory channel ports on the other.
// slave  : the controller's view (takes consumer requests, drives memory requests)
// master : the surrounding system's view (cores and memory model)
interface mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_request;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_request;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic [NUM_CHANNELS-1:0]                 mem_read_request;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_request;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport slave (
    input  consumer_read_request, consumer_read_address,
    input  consumer_write_request, consumer_write_address, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_request, mem_read_address,
    output mem_write_request, mem_write_address, mem_write_data
  );

  modport master (
    output consumer_read_request, consumer_read_address,
    output consumer_write_request, consumer_write_address, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_request, mem_read_address,
    input  mem_write_request, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/mem_controller.sv
// Data memory controller: relays per-thread load/store requests onto a
// smaller set of external memory channels. Each channel owns one consumer
// transaction at a time and holds the consumer's ready until it withdraws.
// Optional build macro MEM_CONTROLLER_RR_ARB_EN: per-channel round-robin
// consumer search; otherwise fixed priority (lowest index wins).
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_controller_if.slave bus
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_t;

  state_t                   r_state      [NUM_CHANNELS];
  state_t                   w_next_state [NUM_CHANNELS];
  logic [CW-1:0]            r_cons       [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_claim;
`ifdef MEM_CONTROLLER_RR_ARB_EN
  logic [CW-1:0]            r_rr_ptr     [NUM_CHANNELS];
`endif

  logic [NUM_CHANNELS-1:0]  w_sel_vld;
  logic [NUM_CHANNELS-1:0]  w_sel_rd;
  logic [CW-1:0]            w_sel_idx    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     w_sel_raddr  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     w_sel_waddr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     w_sel_wdata  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  w_rd_done;
  logic [NUM_CHANNELS-1:0]  w_wr_done;
  logic [NUM_CHANNELS-1:0]  w_release;
  logic [NUM_CONSUMERS-1:0] w_claim_set;
  logic [NUM_CONSUMERS-1:0] w_claim_clr;

  // Arbitration (channels in ascending order, each hiding its pick from the
  // later ones) and next-state / event decode for every channel FSM
  always_comb begin
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [CW-1:0]            w_c;
    w_taken     = r_claim;
    w_c         = '0;
    w_claim_set = '0;
    w_claim_clr = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_next_state[ch] = r_state[ch];
      w_sel_vld[ch]    = 1'b0;
      w_sel_rd[ch]     = 1'b0;
      w_sel_idx[ch]    = '0;
      w_rd_done[ch]    = 1'b0;
      w_wr_done[ch]    = 1'b0;
      w_release[ch]    = 1'b0;
      case (r_state[ch])
        S_IDLE: begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_CONTROLLER_RR_ARB_EN
            w_c = CW'((int'(r_rr_ptr[ch]) + 1 + k) % NUM_CONSUMERS);
`else
            w_c = CW'(k);
`endif
            if (!w_sel_vld[ch] && !w_taken[w_c] &&
                (bus.consumer_read_request[w_c] || bus.consumer_write_request[w_c])) begin
              w_sel_vld[ch]  = 1'b1;
              w_sel_idx[ch]  = w_c;
              // a consumer asking for both is served read first
              w_sel_rd[ch]   = bus.consumer_read_request[w_c];
              w_taken[w_c]   = 1'b1;
            end
          end
          if (w_sel_vld[ch]) begin
            w_next_state[ch]           = w_sel_rd[ch] ? S_READ_WAITING : S_WRITE_WAITING;
            w_claim_set[w_sel_idx[ch]] = 1'b1;
          end
        end
        S_READ_WAITING: begin
          if (bus.mem_read_ready[ch]) begin
            w_rd_done[ch]    = 1'b1;
            w_next_state[ch] = S_READ_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (bus.mem_write_ready[ch]) begin
            w_wr_done[ch]    = 1'b1;
            w_next_state[ch] = S_WRITE_RELAYING;
          end
        end
        S_READ_RELAYING: begin
          if (!bus.consumer_read_request[r_cons[ch]]) begin
            w_release[ch]            = 1'b1;
            w_claim_clr[r_cons[ch]]  = 1'b1;
            w_next_state[ch]         = S_IDLE;
          end
        end
        S_WRITE_RELAYING: begin
          if (!bus.consumer_write_request[r_cons[ch]]) begin
            w_release[ch]            = 1'b1;
            w_claim_clr[r_cons[ch]]  = 1'b1;
            w_next_state[ch]         = S_IDLE;
          end
        end
        default: w_next_state[ch] = S_IDLE;
      endcase
      w_sel_raddr[ch] = bus.consumer_read_address[w_sel_idx[ch]];
      w_sel_waddr[ch] = bus.consumer_write_address[w_sel_idx[ch]];
      w_sel_wdata[ch] = bus.consumer_write_data[w_sel_idx[ch]];
    end
  end

  // Channel state, owned consumer, claim bits and round-robin pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_claim <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch]  <= S_IDLE;
        r_cons[ch]   <= '0;
`ifdef MEM_CONTROLLER_RR_ARB_EN
        // first search after reset starts at consumer 0
        r_rr_ptr[ch] <= CW'(NUM_CONSUMERS - 1);
`endif
      end
    end else begin
      r_claim <= (r_claim & ~w_claim_clr) | w_claim_set;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch] <= w_next_state[ch];
        if (w_sel_vld[ch]) begin
          r_cons[ch]   <= w_sel_idx[ch];
`ifdef MEM_CONTROLLER_RR_ARB_EN
          r_rr_ptr[ch] <= w_sel_idx[ch];
`endif
        end
      end
    end
  end

  // Registered memory-side requests and consumer-side ready/data
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
      bus.mem_read_request     <= '0;
      bus.mem_read_address     <= '0;
      bus.mem_write_request    <= '0;
      bus.mem_write_address    <= '0;
      bus.mem_write_data       <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (w_sel_vld[ch]) begin
          if (w_sel_rd[ch]) begin
            bus.mem_read_request[ch]  <= 1'b1;
            bus.mem_read_address[ch]  <= w_sel_raddr[ch];
          end else begin
            bus.mem_write_request[ch] <= 1'b1;
            bus.mem_write_address[ch] <= w_sel_waddr[ch];
            bus.mem_write_data[ch]    <= w_sel_wdata[ch];
          end
        end
        if (w_rd_done[ch]) begin
          bus.mem_read_request[ch]               <= 1'b0;
          bus.consumer_read_data[r_cons[ch]]     <= bus.mem_read_data[ch];
          bus.consumer_read_ready[r_cons[ch]]    <= 1'b1;
        end
        if (w_wr_done[ch]) begin
          bus.mem_write_request[ch]              <= 1'b0;
          bus.consumer_write_ready[r_cons[ch]]   <= 1'b1;
        end
        if (w_release[ch]) begin
          if (r_state[ch] == S_READ_RELAYING) begin
            bus.consumer_read_ready[r_cons[ch]]  <= 1'b0;
          end else begin
            bus.consumer_write_ready[r_cons[ch]] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
